// File: rtl/instruction_loader.sv
// instruction_loader: frames sync/length/LE-word stream from a byte source into instruction memory writes.
// Optional trailing XOR checksum check enabled by defining INSTR_LOADER_CHECKSUM_EN.
module instruction_loader #(
  parameter int          MAX_WORDS = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [7:0]  SYNC_BYTE = 8'h5A
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic [31:0] byte_address,
  output logic        write_enable,
  output logic [31:0] write_data,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] words_loaded
);
`ifdef INSTR_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_DONE, S_ERROR, S_CHECK} state_t;
  localparam state_t S_FIN = S_CHECK;
  logic [7:0] r_csum;
`else
  typedef enum logic [2:0] {S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_DONE, S_ERROR} state_t;
  localparam state_t S_FIN = S_DONE;
`endif
  localparam logic [15:0] MAX_W = 16'(MAX_WORDS);
  state_t      r_state, w_next;
  logic [15:0] r_len, r_words, w_len;
  logic [23:0] r_buf;
  logic [1:0]  r_idx;
  logic [31:0] r_addr, r_wdata;
  logic        r_we, r_busy, r_done, r_error;
  logic        w_sync, w_take, w_wr, w_start;
  assign w_sync  = rx_valid && rx_data == SYNC_BYTE;
  assign w_len   = {rx_data, r_len[7:0]};
  // Bytes past the final word (before DONE is entered) are not payload.
  assign w_take  = r_state == S_DATA && rx_valid && r_words != r_len;
  assign w_wr    = w_take && r_idx == 2'd3;
  assign w_start = w_next == S_LEN_LO && r_state != S_LEN_LO;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: if (w_sync) w_next = S_LEN_LO;
      S_LEN_LO: if (rx_valid) w_next = S_LEN_HI;
      S_LEN_HI: if (rx_valid) w_next = w_len > MAX_W ? S_ERROR : w_len == 16'd0 ? S_FIN : S_DATA;
`ifdef INSTR_LOADER_CHECKSUM_EN
      S_DATA: if (w_wr && r_words + 16'd1 == r_len) w_next = S_CHECK;
      S_CHECK: if (rx_valid) w_next = rx_data == r_csum ? S_DONE : S_ERROR;
`else
      S_DATA: if (r_words == r_len) w_next = w_sync ? S_LEN_LO : S_DONE;
`endif
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_len   <= '0;
      r_words <= '0;
      r_buf   <= '0;
      r_idx   <= '0;
      r_addr  <= BASE_ADDR;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
      r_csum  <= '0;
`endif
    end else begin
      r_state <= w_next;
      r_we    <= w_wr;
      r_busy  <= w_next != S_IDLE && w_next != S_DONE && w_next != S_ERROR;
      r_done  <= w_next == S_DONE;
      r_error <= w_next == S_ERROR;
      if (r_state == S_LEN_LO && rx_valid) r_len[7:0] <= rx_data;
      if (r_state == S_LEN_HI && rx_valid) r_len[15:8] <= rx_data;
      if (w_take) begin
        r_idx <= r_idx + 2'd1;
        r_buf <= {rx_data, r_buf[23:8]};
      end
      if (w_wr) begin
        r_wdata <= {rx_data, r_buf};
        r_addr  <= BASE_ADDR + {14'd0, r_words, 2'b00};
        r_words <= r_words + 16'd1;
      end
`ifdef INSTR_LOADER_CHECKSUM_EN
      if (w_take) r_csum <= r_csum ^ rx_data;
      if (w_start) r_csum <= '0;
`endif
      if (w_start) begin
        r_words <= '0;
        r_idx   <= '0;
      end
    end
  end
  assign byte_address = r_addr;
  assign write_enable = r_we;
  assign write_data   = r_wdata;
  assign busy         = r_busy;
  assign done         = r_done;
  assign error        = r_error;
  assign words_loaded = r_words;
endmodule

// File: tb/tb_instruction_loader.sv
// tb_instruction_loader: randomized frame stimulus against a word-list model of expected memory writes.
module tb_instruction_loader;
  localparam logic [31:0] BASE = 32'h0000_0000;
  logic        clk = 1'b0, rst = 1'b1, rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic [31:0] byte_address, write_data;
  logic        write_enable, busy, done, error;
  logic [15:0] words_loaded;
  int          checks = 0, errors = 0;
  logic [7:0]  tx_q[$];
  logic [31:0] wq[$];
  logic [63:0] got_q[$];

  always #5 clk = ~clk;

  instruction_loader dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .byte_address(byte_address), .write_enable(write_enable), .write_data(write_data),
    .busy(busy), .done(done), .error(error), .words_loaded(words_loaded)
  );

  always @(posedge clk) begin
    #1;
    if (write_enable) got_q.push_back({byte_address, write_data});
  end

  task automatic build_frame();
    logic [7:0] x;
    x = 8'h00;
    tx_q = {};
    tx_q.push_back(8'h5A);
    tx_q.push_back(8'(wq.size()));
    tx_q.push_back(8'(wq.size() >> 8));
    foreach (wq[i]) for (int k = 0; k < 4; k++) begin
      tx_q.push_back(8'(wq[i] >> (8 * k)));
      x ^= 8'(wq[i] >> (8 * k));
    end
`ifdef INSTR_LOADER_CHECKSUM_EN
    tx_q.push_back(x);
`endif
  endtask

  task automatic send_q(input int maxgap);
    int g;
    foreach (tx_q[i]) begin
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = tx_q[i];
      g = maxgap > 0 ? int'($urandom_range(0, maxgap)) : 0;
      repeat (g) begin
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
      end
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({byte_address, write_enable, write_data, busy, done, error, words_loaded} !== {BASE, 1'b0, 32'h0, 3'b000, 16'h0}) begin
      errors++;
      $display("FAIL reset_values got addr=%h we=%b data=%h busy=%b done=%b err=%b words=%0d", byte_address, write_enable, write_data, busy, done, error, words_loaded);
    end
  endtask

  task automatic test_basic();
    got_q = {};
    wq = {32'h0000_0013, 32'h0010_0093};
    build_frame();
    send_q(0);
    repeat (2) @(negedge clk);
    checks++;
    if (got_q.size() !== 2) begin errors++; $display("FAIL basic_nwrites got %0d exp 2", got_q.size()); end
    else begin
      checks++;
      if (got_q[0] !== {BASE, 32'h0000_0013}) begin errors++; $display("FAIL basic_w0 got %h exp %h", got_q[0], {BASE, 32'h13}); end
      checks++;
      if (got_q[1] !== {BASE + 32'd4, 32'h0010_0093}) begin errors++; $display("FAIL basic_w1 got %h exp %h", got_q[1], {BASE + 32'd4, 32'h00100093}); end
    end
    checks++;
    if ({words_loaded, done, error, busy} !== {16'd2, 3'b100}) begin
      errors++;
      $display("FAIL basic_status got words=%0d done=%b err=%b busy=%b exp 2 1 0 0", words_loaded, done, error, busy);
    end
  endtask

  task automatic test_ignore_idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    got_q = {};
    wq = {$urandom};
    build_frame();
    tx_q.push_front(8'h00);
    tx_q.push_front(8'hFF);
    send_q(2);
    repeat (2) @(negedge clk);
    checks++;
    if (got_q.size() !== 1 || got_q[0] !== {BASE, wq[0]}) begin
      errors++;
      $display("FAIL ignore_idle got n=%0d first=%h exp n=1 %h", got_q.size(), got_q.size() > 0 ? got_q[0] : 64'h0, {BASE, wq[0]});
    end
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL ignore_done got %b exp 1", done); end
  endtask

`ifndef INSTR_LOADER_CHECKSUM_EN
  task automatic test_timing();
    got_q = {};
    wq = {$urandom};
    build_frame();
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = tx_q.pop_front();
    @(negedge clk);
    rx_valid = 1'b0;
    checks++;
    if ({busy, done} !== 2'b10) begin errors++; $display("FAIL busy_rise got busy=%b done=%b exp 1 0", busy, done); end
    send_q(0);
    checks++;
    if ({write_enable, done, busy} !== 3'b101) begin errors++; $display("FAIL strobe_cycle got we=%b done=%b busy=%b exp 1 0 1", write_enable, done, busy); end
    @(negedge clk);
    checks++;
    if ({write_enable, done, busy, words_loaded} !== {3'b010, 16'd1}) begin
      errors++;
      $display("FAIL done_cycle got we=%b done=%b busy=%b words=%0d exp 0 1 0 1", write_enable, done, busy, words_loaded);
    end
  endtask
`endif

  task automatic test_too_long();
    got_q = {};
    tx_q = {8'h5A, 8'h01, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
    send_q(1);
    repeat (2) @(negedge clk);
    checks++;
    if ({error, busy, done} !== 3'b100 || got_q.size() !== 0) begin
      errors++;
      $display("FAIL too_long got err=%b busy=%b done=%b writes=%0d exp 1 0 0 0", error, busy, done, got_q.size());
    end
  endtask

  task automatic test_zero_len();
    got_q = {};
    wq = {};
    build_frame();
    send_q(0);
    repeat (2) @(negedge clk);
    checks++;
    if ({done, error, busy, words_loaded} !== {3'b100, 16'd0} || got_q.size() !== 0) begin
      errors++;
      $display("FAIL zero_len got done=%b err=%b busy=%b words=%0d writes=%0d exp 1 0 0 0 0", done, error, busy, words_loaded, got_q.size());
    end
  endtask

  task automatic test_reset_mid_frame();
    got_q = {};
    wq = {$urandom, $urandom};
    build_frame();
    while (tx_q.size() > 5) void'(tx_q.pop_back());
    send_q(0);
    rst = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h5A;
    @(negedge clk);
    rst = 1'b0;
    rx_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({byte_address, write_enable, write_data, busy, done, error, words_loaded} !== {BASE, 1'b0, 32'h0, 3'b000, 16'h0} || got_q.size() !== 0) begin
      errors++;
      $display("FAIL reset_mid got addr=%h we=%b data=%h busy=%b done=%b err=%b words=%0d writes=%0d", byte_address, write_enable, write_data, busy, done, error, words_loaded, got_q.size());
    end
    wq = {$urandom, $urandom, $urandom};
    build_frame();
    send_q(1);
    repeat (2) @(negedge clk);
    checks++;
    if (got_q.size() !== 3 || got_q[0] !== {BASE, wq[0]} || got_q[2] !== {BASE + 32'd8, wq[2]} || done !== 1'b1) begin
      errors++;
      $display("FAIL reset_reload got n=%0d first=%h done=%b exp n=3 %h 1", got_q.size(), got_q.size() > 0 ? got_q[0] : 64'h0, done, {BASE, wq[0]});
    end
  endtask

  task automatic test_random_frames();
    int n;
    for (int f = 0; f < 6; f++) begin
      got_q = {};
      wq = {};
      n = $urandom_range(1, 12);
      repeat (n) wq.push_back($urandom);
      build_frame();
      send_q(f % 3);
      repeat (2) @(negedge clk);
      checks++;
      if (got_q.size() !== n) begin errors++; $display("FAIL rand%0d_nwrites got %0d exp %0d", f, got_q.size(), n); end
      for (int i = 0; i < n && i < got_q.size(); i++) begin
        checks++;
        if (got_q[i] !== {BASE + 32'(4 * i), wq[i]}) begin
          errors++;
          $display("FAIL rand%0d_w%0d got %h exp %h", f, i, got_q[i], {BASE + 32'(4 * i), wq[i]});
        end
      end
      checks++;
      if ({words_loaded, done, error, busy} !== {16'(n), 3'b100}) begin
        errors++;
        $display("FAIL rand%0d_status got words=%0d done=%b err=%b busy=%b exp %0d 1 0 0", f, words_loaded, done, error, busy, n);
      end
    end
  endtask

  task automatic test_back_to_back_full();
    int bad;
    bad = 0;
    got_q = {};
    wq = {};
    repeat (256) wq.push_back($urandom);
    build_frame();
    send_q(0);
    repeat (2) @(negedge clk);
    checks++;
    if (got_q.size() !== 256) begin errors++; $display("FAIL full_nwrites got %0d exp 256", got_q.size()); end
    for (int i = 0; i < 256 && i < got_q.size(); i++)
      if (got_q[i] !== {BASE + 32'(4 * i), wq[i]}) bad++;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL full_contents got %0d bad words exp 0", bad); end
    checks++;
    if (got_q.size() > 0 && got_q[got_q.size() - 1][63:32] !== BASE + 32'd1020) begin
      errors++;
      $display("FAIL full_last_addr got %h exp %h", got_q[got_q.size() - 1][63:32], BASE + 32'd1020);
    end
    checks++;
    if ({words_loaded, done, error} !== {16'd256, 2'b10}) begin
      errors++;
      $display("FAIL full_status got words=%0d done=%b err=%b exp 256 1 0", words_loaded, done, error);
    end
  endtask

`ifdef INSTR_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    for (int c = 0; c < 2; c++) begin
      got_q = {};
      tx_q = {8'h5A, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, c == 0 ? 8'h44 : 8'h45};
      send_q(c);
      repeat (2) @(negedge clk);
      checks++;
      if (got_q.size() !== 1 || got_q[0] !== {BASE, 32'h4433_2211}) begin
        errors++;
        $display("FAIL csum%0d_write got n=%0d first=%h exp 1 %h", c, got_q.size(), got_q.size() > 0 ? got_q[0] : 64'h0, {BASE, 32'h44332211});
      end
      checks++;
      if ({done, error, busy} !== (c == 0 ? 3'b100 : 3'b010)) begin
        errors++;
        $display("FAIL csum%0d_status got done=%b err=%b busy=%b", c, done, error, busy);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_ignore_idle();
`ifndef INSTR_LOADER_CHECKSUM_EN
    test_timing();
`endif
    test_too_long();
    test_zero_len();
    test_reset_mid_frame();
    test_random_frames();
    test_back_to_back_full();
`ifdef INSTR_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
